// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte FIFO feeding an 8N1 serial transmitter.
// Bytes pushed by the CPU are buffered, then shifted out LSB first with one
// start bit (0) and one stop bit (1). The line idles high and txd is a flop.
// Back-to-back frames run without an idle gap when the FIFO holds more data.
//
// Handshake: tx_valid is a single-cycle push strobe. A push is accepted at the
// rising edge when tx_ready (FIFO not full) is high; a push with tx_ready low
// is dropped and latches the sticky overflow flag until overflow_clr.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    input  logic                         overflow_clr,
    output logic                         txd,
    output logic                         busy,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic [1:0]                   state_dbg
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic [BAUD_W-1:0] baud_q,    baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q,   shift_d;
    logic              txd_q,     txd_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic              ovf_q,     ovf_d;
    logic [7:0]        mem_q [FIFO_DEPTH];

    logic full;
    logic push;
    logic drop;
    logic pop;

    // Fullness is taken from the registered count only, so a pop in the same
    // cycle never rescues a push that arrives while the FIFO is full.
    always_comb begin
        full = (count_q == DEPTH_C);
        push = tx_valid && !full;
        drop = tx_valid && full;
    end

    // Transmit FSM: one baud countdown per bit, reloaded at every bit boundary.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = BAUD_LOAD;
                    txd_d   = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_q == '0) begin
                    baud_d    = BAUD_LOAD;
                    txd_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_LOAD;
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_q == '0) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        baud_d  = BAUD_LOAD;
                        txd_d   = 1'b0;
                        state_d = ST_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping and sticky overflow (a drop wins over a clear).
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (overflow_clr) ovf_d = 1'b0;
        if (drop)         ovf_d = 1'b1;
    end

    // Control state, with the line forced high by reset even mid-frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
        end
    end

    // FIFO storage; only written on an accepted push, so idle tx_data never lands here.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    // Output mapping.
    always_comb begin
        tx_ready   = (count_q != DEPTH_C);
        txd        = txd_q;
        busy       = (state_q != ST_IDLE) || (count_q != '0);
        overflow   = ovf_q;
        fifo_count = count_q;
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A frame-level model (byte queue + position within the current frame) predicts
// all outputs every cycle; a line receiver decodes bytes for a scoreboard; and
// directed tests pin literal values from the hand-worked waveforms.
module tb_uart_tx_serializer;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam int CNT_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             overflow_clr;
  logic             txd;
  logic             busy;
  logic             overflow;
  logic [CNT_W-1:0] fifo_count;
  logic [1:0]       state_dbg;

  int  checks = 0;
  int  errors = 0;
  bit  cmp_en = 1'b0;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .overflow_clr(overflow_clr),
    .txd(txd),
    .busy(busy),
    .overflow(overflow),
    .fifo_count(fifo_count),
    .state_dbg(state_dbg)
  );

  // ---------------- frame-level model ----------------
  logic [7:0] m_q[$];
  bit         m_active;
  int         m_pos;
  logic [7:0] m_byte;
  bit         m_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
    end else begin
      int sz;
      bit do_pop;
      sz = m_q.size();
      do_pop = (!m_active || m_pos == FRAME - 1) && sz > 0;
      if (m_active && m_pos != FRAME - 1) m_pos++;
      else if (do_pop) begin
        m_byte   = m_q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end else m_active = 1'b0;
      if (overflow_clr) m_ovf = 1'b0;
      if (tx_valid) begin
        if (sz == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(tx_data);
      end
    end
  end

  function automatic logic exp_txd();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [6:0] act;
      logic [6:0] exp;
      act = {txd, busy, tx_ready, overflow, fifo_count};
      exp = {exp_txd(), (m_active || m_q.size() != 0), (m_q.size() != DEPTH),
             m_ovf, CNT_W'(m_q.size())};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model_cycle t=%0t {txd,busy,ready,ovf,count} got %b want %b",
                 $time, act, exp);
      end
    end
  end

  // ---------------- line receiver + scoreboard ----------------
  logic [7:0] rx_log[$];
  logic [7:0] exp_q[$];
  int         rst_events = 0;

  always @(posedge rst) rst_events++;

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en && !rst && txd === 1'b0) begin
        int ev;
        logic [7:0] b;
        ev = rst_events;
        repeat (6) @(negedge clk);
        b[0] = txd;
        for (int i = 1; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        if (ev == rst_events && txd === 1'b1) rx_log.push_back(b);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_rx(input string name);
    check({name, "_count"}, rx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_log.size(); i++)
      check({name, "_byte"}, {24'd0, rx_log[i]}, {24'd0, exp_q[i]});
    rx_log.delete();
    exp_q.delete();
  endtask

  // ---------------- directed tests ----------------
  logic a5_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int bc;
    int peak;
    logic stop_tx, start_tx;

    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    overflow_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    check("reset_outputs", {25'd0, txd, busy, tx_ready, overflow, fifo_count}, {25'd0, 7'b1_0_1_0_000});
    rst = 1'b0;

    // Idle for 50 cycles.
    repeat (50) tick();
    check("idle_outputs", {25'd0, txd, busy, tx_ready, overflow, fifo_count}, {25'd0, 7'b1_0_1_0_000});

    // Single byte 0xA5.
    push(8'hA5);
    check("a5_count_after_push", fifo_count, 1);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      check("a5_line_bit", {31'd0, txd}, {31'd0, a5_bits[i / CPB]});
    end
    check("a5_busy_k40", {31'd0, busy}, 32'd1);
    tick();
    check("a5_busy_k41", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'hA5);
    repeat (4) tick();
    check_rx("a5_rx");

    // Back-to-back 0x00, 0xFF.
    push(8'h00);
    peak = fifo_count;
    push(8'hFF);
    bc = 0;
    stop_tx = 1'bx;
    start_tx = 1'bx;
    while (busy === 1'b1 && bc < 200) begin
      if (fifo_count > peak) peak = fifo_count;
      if (bc == 39) stop_tx = txd;
      if (bc == 40) start_tx = txd;
      bc++;
      tick();
    end
    check("b2b_busy_cycles", bc, 80);
    check("b2b_peak_count", peak, 1);
    check("b2b_stop_bit", {31'd0, stop_tx}, 32'd1);
    check("b2b_next_start", {31'd0, start_tx}, 32'd0);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    repeat (4) tick();
    check_rx("b2b_rx");

    // Overflow: 0x10..0x15, the last one dropped.
    for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
    check("ovf_ready_full", {31'd0, tx_ready}, 32'd0);
    check("ovf_count_full", fifo_count, 4);
    check("ovf_flag_before", {31'd0, overflow}, 32'd0);
    push(8'h15);
    check("ovf_flag_set", {31'd0, overflow}, 32'd1);
    check("ovf_count_after_drop", fifo_count, 4);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_flag_cleared", {31'd0, overflow}, 32'd0);
    wait_idle(400);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h10 + i));
    repeat (4) tick();
    check_rx("ovf_rx");

    // Clear/set collision, then a drop on the same edge as a pop.
    for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
    tx_valid = 1'b1;
    tx_data = 8'h25;
    overflow_clr = 1'b1;
    tick();
    tx_valid = 1'b0;
    overflow_clr = 1'b0;
    check("collide_ovf_wins", {31'd0, overflow}, 32'd1);
    check("collide_count", fifo_count, 4);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("collide_cleared", {31'd0, overflow}, 32'd0);
    repeat (34) tick();
    check("pop_edge_count_before", fifo_count, 4);
    push(8'h26);
    check("pop_edge_drop_ovf", {31'd0, overflow}, 32'd1);
    check("pop_edge_count_after", fifo_count, 3);
    wait_idle(400);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h20 + i));
    repeat (4) tick();
    check_rx("collide_rx");
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;

    // Reset during data bit 3 of 0x3C with two bytes queued.
    push(8'h3C);
    push(8'h55);
    push(8'h66);
    check("mid_count_queued", fifo_count, 2);
    repeat (16) tick();
    check("mid_bit3_value", {31'd0, txd}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_async_reset", {25'd0, txd, busy, tx_ready, overflow, fifo_count}, {25'd0, 7'b1_0_1_0_000});
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) tick();
    check("mid_no_frames_txd", {31'd0, txd}, 32'd1);
    check("mid_no_frames_rx", rx_log.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit end of the CPU's byte-stream UART interface.
- Accepts bytes pushed by `cpu.uart_tx_data`/`uart_tx_valid` into a small FIFO and serialises them onto one line as 8N1 frames.
- Sits beside `cpu`/`memory` in the system wrapper and drives the chip-level TX pin.
- Has its own baud-tick counter; no external baud enable.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit (legal range 2..65535).
- FIFO_DEPTH, 4, byte entries in the TX FIFO (power of two, at least 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to send; sampled when tx_valid=1.
- tx_valid  input  1  single-cycle push strobe from the CPU.
- tx_ready  output  1  1 when the FIFO is not full.
- overflow_clr  input  1  clears the sticky overflow flag.
- txd  output  1  serial line, idle high, registered.
- busy  output  1  1 while a frame is on the line or the FIFO is non-empty.
- overflow  output  1  sticky: a push was dropped.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, active-high) forces: txd=1, busy=0, overflow=0, fifo_count=0, tx_ready=1, FSM=IDLE, baud and bit counters=0, FIFO emptied. This also applies mid-frame: the line returns high immediately and the partial frame is abandoned.
- FIFO push: tx_valid=1 with count<FIFO_DEPTH writes tx_data at the edge, and count increments.
- Push while full: the byte is dropped and overflow is set at the edge. This holds even if a pop occurs in the same cycle.
- Simultaneous push (not full) and pop: count is unchanged and both operations take effect.
- tx_ready is equal to (count != FIFO_DEPTH). It is combinational from the registered count.
- overflow_clr=1 clears overflow at the edge. If a dropped push happens in the same cycle, set wins.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: txd=1. If count>0, pop the head into the shift register, load the baud counter with CLKS_PER_BIT-1, drive txd=0 and go to START.
  - START: hold for CLKS_PER_BIT cycles, then drive txd=shift[0], bit index=0, and go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles. Bits are sent LSB first. After bit 7, drive txd=1 and go to STOP.
  - STOP: hold for CLKS_PER_BIT cycles. At the end, if count>0, pop and go directly to START with txd=0 (no idle gap); otherwise go to IDLE.
- Latency: push at edge k puts the byte in the FIFO after k. IDLE pops at edge k+1, and txd falls at k+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- The baud counter counts down to 0 and reloads on each bit boundary. It never wraps mid-bit.
- busy = (state != IDLE) or (count != 0).
- tx_data is irrelevant when tx_valid=0; no X propagation into the FIFO.

Test Plan:
- Reset and idle: assert reset for 3 cycles, release, run 50 cycles with no push -> txd=1, busy=0, tx_ready=1, overflow=0, fifo_count=0 throughout.
- Single byte: CLKS_PER_BIT=4, push 0xA5 at edge k.
  - txd from k+1 is 0 | 1,0,1,0,0,1,0,1 | 1, with each bit lasting 4 cycles.
  - busy drops at k+41.
- Back-to-back: push 0x00 and 0xFF on consecutive cycles.
  - Two frames are contiguous: stop bit of frame 1 is immediately followed by the start bit of frame 2.
  - Total busy time is 80 cycles; fifo_count peaks at 1.
- Overflow: FIFO_DEPTH=4, push 6 bytes 0x10..0x15 in 6 consecutive cycles.
  - The first byte is popped at once and 4 more are buffered, so 0x15 is dropped.
  - tx_ready=0 while count=4; overflow=1 after the 6th push.
  - Line carries 0x10..0x14 only.
  - overflow_clr then clears overflow.
- Reset mid-frame: assert reset during DATA bit 3 of 0x3C with 2 bytes queued -> txd=1 immediately (asynchronously), fifo_count=0, and no further frames after release.
- Overflow clear vs set collision: full FIFO, overflow_clr=1 and tx_valid=1 in the same cycle -> overflow=1 afterwards.
